// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and sizes for the RAW-hazard scoreboard and the ID/EX pipeline register.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_entry_match.sv
// Compares one in-flight destination entry against a source register index; x0 never matches.
module sb_entry_match
    import hazard_scoreboard_pkg::*;
(
    input  sb_entry_t             entry,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  hit
);

    assign hit = entry.valid && (entry.rd == addr) && (addr != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard interlock for the non-forwarding 5-stage pipeline: tracks rd in EX/MEM/WB and
// stalls ID while a used source operand is still pending.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter bit          WB_BYPASS   = 1'b0,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_id_valid,
    input  logic [REG_ADDR_W-1:0]  i_id_rs1_addr,
    input  logic                   i_id_rs1_used,
    input  logic [REG_ADDR_W-1:0]  i_id_rs2_addr,
    input  logic                   i_id_rs2_used,
    input  logic [REG_ADDR_W-1:0]  i_id_rd_addr,
    input  logic                   i_id_rd_wren,
    input  logic                   i_flush,
    output logic                   o_stall,
    output logic                   o_ex_bubble,
    output logic [NUM_REGS-1:0]    o_pending_mask,
    output logic [STALL_CNT_W-1:0] o_stall_cycles
);

    localparam int unsigned NUM_ENTRIES = 3;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    sb_entry_t              entries [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] rs1_hit, rs2_hit;
    logic                   rs1_match, rs2_match, hazard, issue;

    assign entries[0] = ex_q;
    assign entries[1] = mem_q;
    assign entries[2] = wb_q;

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_match
        sb_entry_match u_rs1 (.entry(entries[e]), .addr(i_id_rs1_addr), .hit(rs1_hit[e]));
        sb_entry_match u_rs2 (.entry(entries[e]), .addr(i_id_rs2_addr), .hit(rs2_hit[e]));
    end

    // With a write-through regfile the WB slot is already readable, so it never blocks.
    assign rs1_match = rs1_hit[0] || rs1_hit[1] || (!WB_BYPASS && rs1_hit[2]);
    assign rs2_match = rs2_hit[0] || rs2_hit[1] || (!WB_BYPASS && rs2_hit[2]);

    assign hazard      = i_id_valid && ((i_id_rs1_used && rs1_match) || (i_id_rs2_used && rs2_match));
    assign o_stall     = hazard && !i_flush;
    assign issue       = i_id_valid && !hazard && !i_flush;
    assign o_ex_bubble = !issue;

    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.valid = i_id_rd_wren && (i_id_rd_addr != '0);
            ex_d.rd    = i_id_rd_addr;
        end
    end

    always_comb begin
        o_pending_mask = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (entries[e].valid) begin
                o_pending_mask[entries[e].rd] = 1'b1;
            end
        end
    end

    // Entries always advance; only ID is ever held.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (o_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
        end
    end

    assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one instance per WB_BYPASS setting, both fed the same ID stream
// and checked against an issue-history model.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid, rs1_used, rs2_used, rd_wren, flush;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;

    logic        stall0, bubble0, stall1, bubble1;
    logic [31:0] mask0, mask1;
    logic [15:0] cyc0;
    logic [3:0]  cyc1;

    int n_vec = 0;
    int n_err = 0;

    // Model: rd of the last three issued writers (0 = nothing tracked), newest first.
    int hist [2][3];
    int cnt  [2];
    int cmax [2] = '{65535, 15};
    int win  [2] = '{3, 2};

    hazard_scoreboard #(.WB_BYPASS(1'b0), .STALL_CNT_W(16)) u_dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_id_valid(id_valid),
        .i_id_rs1_addr(rs1_addr), .i_id_rs1_used(rs1_used),
        .i_id_rs2_addr(rs2_addr), .i_id_rs2_used(rs2_used),
        .i_id_rd_addr(rd_addr), .i_id_rd_wren(rd_wren), .i_flush(flush),
        .o_stall(stall0), .o_ex_bubble(bubble0), .o_pending_mask(mask0), .o_stall_cycles(cyc0)
    );

    hazard_scoreboard #(.WB_BYPASS(1'b1), .STALL_CNT_W(4)) u_dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_id_valid(id_valid),
        .i_id_rs1_addr(rs1_addr), .i_id_rs1_used(rs1_used),
        .i_id_rs2_addr(rs2_addr), .i_id_rs2_used(rs2_used),
        .i_id_rd_addr(rd_addr), .i_id_rd_wren(rd_wren), .i_flush(flush),
        .o_stall(stall1), .o_ex_bubble(bubble1), .o_pending_mask(mask1), .o_stall_cycles(cyc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit pending(input int k, input int a);
        if (a == 0) return 1'b0;
        for (int i = 0; i < win[k]; i++)
            if (hist[k][i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_mask(input int k);
        logic [31:0] m = '0;
        for (int i = 0; i < 3; i++)
            if (hist[k][i] != 0) m[hist[k][i]] = 1'b1;
        return m;
    endfunction

    // One ID cycle: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic apply(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int rd, input bit wr, input bit fl, input bit rst);
        bit hz [2];
        bit st [2];
        bit is [2];
        @(negedge clk);
        id_valid = v;  rs1_addr = 5'(r1); rs1_used = u1; rs2_addr = 5'(r2); rs2_used = u2;
        rd_addr = 5'(rd); rd_wren = wr; flush = fl; rst_n = rst;
        #1;
        for (int k = 0; k < 2; k++) begin
            hz[k] = v && ((u1 && pending(k, r1)) || (u2 && pending(k, r2)));
            st[k] = hz[k] && !fl;
            is[k] = v && !hz[k] && !fl;
        end
        check_eq("stall0",  32'(stall0),  32'(st[0]));
        check_eq("bubble0", 32'(bubble0), 32'(!is[0]));
        check_eq("mask0",   mask0,        model_mask(0));
        check_eq("cycles0", 32'(cyc0),    32'(cnt[0]));
        check_eq("stall1",  32'(stall1),  32'(st[1]));
        check_eq("bubble1", 32'(bubble1), 32'(!is[1]));
        check_eq("mask1",   mask1,        model_mask(1));
        check_eq("cycles1", 32'(cyc1),    32'(cnt[1]));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                hist[k] = '{0, 0, 0};
                cnt[k]  = 0;
            end else begin
                if (st[k] && cnt[k] < cmax[k]) cnt[k]++;
                hist[k][2] = hist[k][1];
                hist[k][1] = hist[k][0];
                hist[k][0] = (is[k] && wr) ? rd : 0;
            end
        end
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int r1, r2, rd;
        bit u1, u2, wr, v;
        id_valid = 0; rs1_addr = 0; rs1_used = 0; rs2_addr = 0; rs2_used = 0;
        rd_addr = 0; rd_wren = 0; flush = 0; rst_n = 0;
        hist = '{'{0, 0, 0}, '{0, 0, 0}};
        cnt  = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall",  32'(stall0), 32'd0);
        check_eq("rst_mask",   mask0,       32'd0);
        check_eq("rst_cycles", 32'(cyc0),   32'd0);

        // Producer x5, consumer reads x5: 3 stalls without bypass, 2 with.
        do_reset();
        apply(1, 0, 0, 0, 0, 5, 1, 0, 1);
        repeat (4) apply(1, 5, 1, 0, 0, 0, 0, 0, 1);
        idle();
        #1;
        check_eq("raw_cnt_nobyp", 32'(cyc0), 32'd3);
        check_eq("raw_cnt_byp",   32'(cyc1), 32'd2);

        // x0 is never tracked.
        do_reset();
        apply(1, 0, 0, 0, 0, 0, 1, 0, 1);
        apply(1, 0, 1, 0, 1, 0, 0, 0, 1);
        idle();

        // Unused rs2 does not stall; used rs2 does.
        do_reset();
        apply(1, 0, 0, 0, 0, 7, 1, 0, 1);
        apply(1, 0, 0, 7, 0, 0, 0, 0, 1);
        repeat (3) apply(1, 0, 0, 7, 1, 0, 0, 0, 1);
        idle();

        // Two producers back-to-back, consumer needs both; also self rs==rd.
        do_reset();
        apply(1, 0, 0, 0, 0, 3, 1, 0, 1);
        apply(1, 0, 0, 0, 0, 4, 1, 0, 1);
        repeat (4) apply(1, 3, 1, 4, 1, 3, 1, 0, 1);
        apply(1, 6, 1, 6, 1, 6, 1, 0, 1);
        idle();

        // Flush during a stall on x9.
        do_reset();
        apply(1, 0, 0, 0, 0, 9, 1, 0, 1);
        apply(1, 9, 1, 0, 0, 0, 0, 0, 1);
        apply(1, 9, 1, 0, 0, 0, 0, 1, 1);
        idle();
        #1;
        check_eq("flush_cnt", 32'(cyc0), 32'd1);

        // Reset mid-stall.
        apply(1, 0, 0, 0, 0, 9, 1, 0, 1);
        apply(1, 9, 1, 0, 0, 0, 0, 0, 1);
        apply(1, 9, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check_eq("rst_mid_mask",  mask0,       32'd0);
        check_eq("rst_mid_stall", 32'(stall0), 32'd0);
        check_eq("rst_mid_cnt",   32'(cyc0),   32'd0);

        // Random stream; a stalled instruction is usually re-presented as real ID would.
        v = 0; r1 = 0; r2 = 0; rd = 0; u1 = 0; u2 = 0; wr = 0;
        for (int n = 0; n < 2000; n++) begin
            bit fl, rs;
            if (!(stall0 && ($urandom_range(0, 3) != 0))) begin
                v  = ($urandom_range(0, 7) != 0);
                r1 = $urandom_range(0, 7);  u1 = $urandom_range(0, 1);
                r2 = $urandom_range(0, 7);  u2 = $urandom_range(0, 1);
                rd = $urandom_range(0, 7);  wr = ($urandom_range(0, 3) != 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 399) != 0);
            apply(v, r1, u1, r2, u2, rd, wr, fl, rs);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
